// File: rtl/cpu_ctrl_pkg.sv
// Shared control-bus definitions for the CPU datapath and its microsequencer:
// bus IDs, address-master IDs, opcodes, control word layout and FSM states.
package cpu_ctrl_pkg;

   localparam int CB_W  = 33;
   localparam int CW_W  = 20;
   localparam int ID_W  = 5;
   localparam int AM_W  = 2;
   localparam int ALU_W = 5;

   // Bit offsets of the control word fields inside control_bus.
   localparam int CB_SID_EN = 0;
   localparam int CB_MID_EN = 1;
   localparam int CB_PC_INR = 2;
   localparam int CB_AMID   = 3;
   localparam int CB_SID    = 5;
   localparam int CB_MID    = 10;
   localparam int CB_ALU    = 15;

   localparam logic [ID_W-1:0] ID_IR0 = 5'd0;
   localparam logic [ID_W-1:0] ID_IR1 = 5'd1;
   localparam logic [ID_W-1:0] ID_A   = 5'd2;
   localparam logic [ID_W-1:0] ID_B   = 5'd3;
   localparam logic [ID_W-1:0] ID_MEM = 5'd4;
   localparam logic [ID_W-1:0] ID_R0  = 5'd5;
   localparam logic [ID_W-1:0] ID_R1  = 5'd6;
   localparam logic [ID_W-1:0] ID_AR0 = 5'd7;
   localparam logic [ID_W-1:0] ID_AR1 = 5'd8;
   localparam logic [ID_W-1:0] ID_PC0 = 5'd9;
   localparam logic [ID_W-1:0] ID_PC1 = 5'd10;
   localparam logic [ID_W-1:0] ID_SP0 = 5'd11;
   localparam logic [ID_W-1:0] ID_SP1 = 5'd12;
   localparam logic [ID_W-1:0] ID_SR  = 5'd17;
   localparam logic [ID_W-1:0] ID_ALU = 5'd18;

   localparam logic [AM_W-1:0] AM_PC   = 2'd0;
   localparam logic [AM_W-1:0] AM_AR   = 2'd1;
   localparam logic [AM_W-1:0] AM_SP   = 2'd2;
   localparam logic [AM_W-1:0] AM_R0R1 = 2'd3;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_MOV = 8'h01;
   localparam logic [7:0] OP_LDA = 8'h40;
   localparam logic [7:0] OP_STA = 8'h41;
   localparam logic [7:0] OP_JMP = 8'h80;
   localparam logic [7:0] OP_JZ  = 8'h81;
   localparam logic [7:0] OP_HLT = 8'hFF;

   // Field order matches the LSB-aligned control_bus layout.
   typedef struct packed {
      logic [ALU_W-1:0] alu;
      logic [ID_W-1:0]  mid;
      logic [ID_W-1:0]  sid;
      logic [AM_W-1:0]  amid;
      logic             pc_inr;
      logic             mid_en;
      logic             sid_en;
   } ctrl_word_t;

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } cu_state_t;

   // One bus transfer: master drives, slave captures.
   function automatic ctrl_word_t xfer(
      input logic [AM_W-1:0] amid,
      input logic [ID_W-1:0] mid,
      input logic [ID_W-1:0] sid,
      input logic            pc_inr
   );
      ctrl_word_t w;
      w        = '0;
      w.amid   = amid;
      w.mid    = mid;
      w.sid    = sid;
      w.pc_inr = pc_inr;
      w.mid_en = 1'b1;
      w.sid_en = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational micro-step decoder: (opcode, IR1, T, status) -> control word,
// last_step flag and illegal-opcode flag. Holds no state.
module cu_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int Z_BIT = 0
) (
   input  logic [7:0]  opcode,
   input  logic [7:0]  ir1,
   input  logic [3:0]  t,
   input  logic [3:0]  status,
   output ctrl_word_t  word,
   output logic        last_step,
   output logic        illegal
);

   logic is_mov, is_alu, is_ldst, is_lda, is_jmp, is_jz;
   logic is_known, jmp_path, jz_skip;
   logic unused_status;

   assign is_mov  = (opcode == OP_MOV);
   assign is_alu  = (opcode[7:5] == 3'b001);
   assign is_lda  = (opcode == OP_LDA);
   assign is_ldst = is_lda | (opcode == OP_STA);
   assign is_jmp  = (opcode == OP_JMP);
   assign is_jz   = (opcode == OP_JZ);

   assign is_known = is_mov | is_alu | is_ldst | is_jmp | is_jz
                   | (opcode == OP_NOP) | (opcode == OP_HLT);

   // The branch decision is made at T2; T3/T4 are only reached when taken.
   assign jmp_path = is_jmp
                   | (is_jz & ((t != 4'd2) | status[Z_BIT]));
   assign jz_skip  = is_jz & ~jmp_path;

   assign unused_status = ^status;

   always_comb begin
      word      = '0;
      last_step = 1'b0;
      illegal   = 1'b0;
      if (t == 4'd0) begin
         word = xfer(AM_PC, ID_MEM, ID_IR0, 1'b1);
      end else if (t == 4'd1) begin
         word = xfer(AM_PC, ID_MEM, ID_IR1, 1'b1);
      end else begin
         unique case (1'b1)
            is_mov: begin
               word = xfer(AM_PC, {1'b0, ir1[3:0]},
                           {1'b0, ir1[7:4]}, 1'b0);
               last_step = 1'b1;
            end
            is_alu: begin
               word     = xfer(AM_PC, ID_ALU, ID_A, 1'b0);
               word.alu = opcode[4:0];
               last_step = 1'b1;
            end
            is_ldst: begin
               if (t == 4'd2) begin
                  word = xfer(AM_PC, ID_IR1, ID_AR0, 1'b0);
               end else if (t == 4'd3) begin
                  word = xfer(AM_PC, ID_MEM, ID_AR1, 1'b1);
               end else begin
                  word = is_lda ? xfer(AM_AR, ID_MEM, ID_A, 1'b0)
                                : xfer(AM_AR, ID_A, ID_MEM, 1'b0);
                  last_step = 1'b1;
               end
            end
            jmp_path: begin
               if (t == 4'd2) begin
                  word = xfer(AM_PC, ID_MEM, ID_AR1, 1'b0);
               end else if (t == 4'd3) begin
                  word = xfer(AM_PC, ID_IR1, ID_PC0, 1'b0);
               end else begin
                  word = xfer(AM_PC, ID_AR1, ID_PC1, 1'b0);
                  last_step = 1'b1;
               end
            end
            jz_skip: begin
               // Step over the unused high target byte.
               word.pc_inr = 1'b1;
               last_step   = 1'b1;
            end
            default: begin
               last_step = 1'b1;
               illegal   = ~is_known;
            end
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired microsequencer: owns RUN/HALT state, micro-step T and sticky halt.
// Ports: clk, reset (async low), hlt, instr, status -> control_bus, T, halted, illegal.
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int Z_BIT = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            hlt,
   input  logic [15:0]     instr,
   input  logic [3:0]      status,
   output logic [CB_W-1:0] control_bus,
   output logic [3:0]      T,
   output logic            halted,
   output logic            illegal
);

   cu_state_t  state_q, state_d;
   logic [3:0] t_q, t_d;
   logic       sticky_q, sticky_d;

   ctrl_word_t word;
   logic       last_step;
   logic       dec_illegal;

   cu_decode #(
      .Z_BIT(Z_BIT)
   ) u_decode (
      .opcode    (instr[7:0]),
      .ir1       (instr[15:8]),
      .t         (t_q),
      .status    (status),
      .word      (word),
      .last_step (last_step),
      .illegal   (dec_illegal)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RUN;
         t_q      <= 4'd0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      sticky_d = sticky_q;
      unique case (state_q)
         ST_RUN: begin
            if (last_step) begin
               t_d = 4'd0;
               if (instr[7:0] == OP_HLT) begin
                  state_d  = ST_HALT;
                  sticky_d = 1'b1;
               end else if (hlt) begin
                  state_d = ST_HALT;
               end
            end else begin
               t_d = t_q + 4'd1;
            end
         end
         ST_HALT: begin
            t_d = 4'd0;
            if (!hlt && !sticky_q) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            t_d     = 4'd0;
         end
      endcase
   end

   assign halted      = (state_q == ST_HALT);
   assign T           = t_q;
   assign illegal     = (state_q == ST_RUN) & dec_illegal;
   assign control_bus = halted ? '0 : {{(CB_W-CW_W){1'b0}}, word};

endmodule
